alu_issue_wb: RTL and testbench

// - Execute-stage wrapper on both sides of the combinational ALU: reads operands

---
 rtl/alu_issue_wb.sv | 139 +++++++++++++
 tb/tb_alu_issue_wb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: two-stage (EX -> WB) execute wrapper around an external
// combinational ALU, with a 32x32 register file and valid/ready on both ends.
// Optional macro ISSUE_BYPASS_EN: forward the EX-stage ALU result to the
// operands of the instruction being issued. When it is undefined, a dependent
// instruction is held off for one cycle instead.
module alu_issue_wb #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output logic [4:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_zero
);

    typedef struct packed {
        logic [4:0]        op;
        logic [4:0]        rd;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } ex_t;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic              zero;
    } wb_t;

    logic              ex_valid_q, ex_valid_d;
    ex_t               ex_q, ex_d;
    logic              wb_valid_q, wb_valid_d;
    wb_t               wb_q, wb_d;
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];

    logic              stall, ex_adv, issue, raw_hazard;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_ext, opa, opb;

    // Operand fetch, hazard/bypass selection and handshake.
    always_comb begin
        stall   = wb_valid_q & ~wb_ready;
        // A flushed EX instruction must never reach WB or the register file.
        ex_adv  = ex_valid_q & ~stall & ~flush;
        rs1_val = (in_rs1 == 5'd0) ? '0 : rf_q[in_rs1];
        rs2_val = (in_rs2 == 5'd0) ? '0 : rf_q[in_rs2];
        imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
`ifdef ISSUE_BYPASS_EN
        // Issue with a live EX producer implies EX advances on this edge,
        // so alu_result is exactly the value about to land in R[ex_rd].
        raw_hazard = 1'b0;
        opa = (ex_valid_q && ex_q.rd != 5'd0 && ex_q.rd == in_rs1) ? alu_result : rs1_val;
        opb = in_use_imm ? imm_ext :
              ((ex_valid_q && ex_q.rd != 5'd0 && ex_q.rd == in_rs2) ? alu_result : rs2_val);
`else
        raw_hazard = ex_valid_q & (ex_q.rd != 5'd0) &
                     ((ex_q.rd == in_rs1) | (~in_use_imm & (ex_q.rd == in_rs2)));
        opa = rs1_val;
        opb = in_use_imm ? imm_ext : rs2_val;
`endif
        in_ready = ~flush & ~(ex_valid_q & stall) & ~raw_hazard;
        issue    = in_valid & in_ready;
    end

    // EX stage next state: flush kills, issue loads, advance empties.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (issue) begin
            ex_valid_d = 1'b1;
            ex_d.op    = in_op;
            ex_d.rd    = in_rd;
            ex_d.a     = opa;
            ex_d.b     = opb;
        end else if (ex_adv) begin
            ex_valid_d = 1'b0;
        end
    end

    // WB stage next state and register-file write on EX advance.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_d       = wb_q;
        rf_d       = rf_q;
        if (ex_adv) begin
            wb_valid_d = 1'b1;
            wb_d.rd    = ex_q.rd;
            wb_d.data  = alu_result;
            wb_d.zero  = alu_zero;
            if (ex_q.rd != 5'd0) rf_d[ex_q.rd] = alu_result;
        end else if (!stall) begin
            wb_valid_d = 1'b0;
        end
    end

    // Pipeline and register-file state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
            rf_q       <= '{default: '0};
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
            rf_q       <= rf_d;
        end
    end

    assign alu_operand_a = ex_q.a;
    assign alu_operand_b = ex_q.b;
    assign alu_control   = ex_q.op;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_q.rd;
    assign wb_data       = wb_q.data;
    assign wb_zero       = wb_q.zero;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb: an architectural model executes each
// accepted instruction in program order and queues the expected retirement;
// a monitor pops and compares whenever WB hands a result downstream.
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [15:0] in_imm = '0;
    logic        in_use_imm = 1'b0;
    logic [31:0] alu_operand_a, alu_operand_b, alu_result;
    logic [4:0]  alu_control;
    logic        alu_zero;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_zero;

    alu_issue_wb #(.DATA_W(32), .IMM_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_zero(wb_zero)
    );

    always #5 clk = ~clk;

    // Op codes of the bench's ALU; anything else returns 0.
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_OR = 5'd3;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0: return a + b;
            5'd1: return a - b;
            5'd2: return a & b;
            5'd3: return a | b;
            5'd4: return a ^ b;
            5'd5: return a << b[4:0];
            5'd6: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    // External combinational ALU.
    always_comb begin
        alu_result = alu_f(alu_control, alu_operand_a, alu_operand_b);
        alu_zero   = (alu_result == 32'd0);
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    exp_t        expq[$];
    int          ret_log[$];
    logic [31:0] mreg [32];
    int          tests = 0, fails = 0, cyc = 0, last_acc_cyc = 0;
    logic [4:0]  last_rd;
    logic [31:0] last_old;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Architectural reference: sequential execution on an array of registers.
    task automatic model_exec(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [15:0] imm, input logic ui);
        logic [31:0] a, b, r;
        exp_t e;
        a = mreg[rs1];
        b = ui ? {{16{imm[15]}}, imm} : mreg[rs2];
        r = alu_f(op, a, b);
        last_rd  = rd;
        last_old = mreg[rd];
        if (rd != 5'd0) mreg[rd] = r;
        e.rd = rd; e.data = r; e.zero = (r == 32'd0);
        expq.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
    endtask

    // One cycle of presentation; returns whether the instruction was taken.
    task automatic issue_once(input logic v, input logic [4:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [15:0] imm, input logic ui, input logic fl,
                              output logic acc);
        @(negedge clk);
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_use_imm = ui; flush = fl;
        #2;
        acc = v & in_ready;
        last_acc_cyc = cyc;
        if (acc) model_exec(op, rd, rs1, rs2, imm, ui);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [15:0] imm, input logic ui);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) issue_once(1'b1, op, rd, rs1, rs2, imm, ui, 1'b0, acc);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int t;
        in_valid = 1'b0;
        wb_ready = 1'b1;
        t = 0;
        while (expq.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain", expq.size(), 0);
    endtask

    // Monitor: compare every handed-off WB result with the queue head.
    always @(negedge clk) begin
        #3;
        if (rst_n && wb_valid && wb_ready) begin
            exp_t e;
            ret_log.push_back(cyc);
            if (expq.size() == 0) begin
                chk("wb_unexpected", {wb_rd, wb_data}, 0);
            end else begin
                e = expq.pop_front();
                chk("wb_result", {wb_rd, wb_data, wb_zero}, {e.rd, e.data, e.zero});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   a1;
        model_clear();

        // Reset state
        #2;
        chk("reset_outputs", {wb_valid, wb_rd, wb_data, wb_zero, alu_operand_a, alu_operand_b, alu_control}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI r1,r0,5 ; ADD r2,r1,r1 back-to-back
        ret_log.delete();
        send(OP_ADD, 5'd1, 5'd0, 5'd0, 16'd5, 1'b1);
        a1 = last_acc_cyc;
        send(OP_ADD, 5'd2, 5'd1, 5'd1, 16'd0, 1'b0);
        wait_drain();
        chk("dep_retire_count", ret_log.size(), 2);
        if (ret_log.size() == 2) begin
            chk("issue_to_wb_latency", ret_log[0] - a1, 2);
`ifdef ISSUE_BYPASS_EN
            chk("dep_retire_gap", ret_log[1] - ret_log[0], 1);
`else
            chk("dep_retire_gap", ret_log[1] - ret_log[0], 2);
`endif
        end

        // ADDI r3,r0,-1 ; SUB r4,r3,r3
        send(OP_ADD, 5'd3, 5'd0, 5'd0, 16'hFFFF, 1'b1);
        send(OP_SUB, 5'd4, 5'd3, 5'd3, 16'd0, 1'b0);
        wait_drain();

        // Backpressure: WB and EX fill, third instruction held off
        ret_log.delete();
        wb_ready = 1'b0;
        send(OP_ADD, 5'd10, 5'd0, 5'd0, 16'd100, 1'b1);
        send(OP_ADD, 5'd11, 5'd0, 5'd0, 16'd200, 1'b1);
        for (int i = 0; i < 3; i++) begin
            issue_once(1'b1, OP_ADD, 5'd12, 5'd0, 5'd0, 16'd300, 1'b1, 1'b0, acc);
            chk("stall_in_ready", acc, 0);
            chk("stall_wb_valid", wb_valid, 1);
            chk("stall_wb_data", wb_data, expq[0].data);
        end
        wb_ready = 1'b1;
        send(OP_ADD, 5'd12, 5'd0, 5'd0, 16'd300, 1'b1);
        wait_drain();
        chk("stall_retire_count", ret_log.size(), 3);

        // Flush with EX holding ADDI r5,r0,7 and WB holding ADDI r9,r0,1
        wb_ready = 1'b0;
        send(OP_ADD, 5'd9, 5'd0, 5'd0, 16'd1, 1'b1);
        send(OP_ADD, 5'd5, 5'd0, 5'd0, 16'd7, 1'b1);
        issue_once(1'b1, OP_ADD, 5'd13, 5'd0, 5'd0, 16'd3, 1'b1, 1'b1, acc);
        chk("flush_not_accepted", acc, 0);
        void'(expq.pop_back());
        mreg[last_rd] = last_old;
        ret_log.delete();
        wait_drain();
        chk("flush_retire_count", ret_log.size(), 1);
        send(OP_ADD, 5'd7, 5'd5, 5'd0, 16'd0, 1'b0);
        wait_drain();

        // Writes to r0 retire but are discarded; no bypass from rd=0
        send(OP_ADD, 5'd0, 5'd0, 5'd0, 16'd9, 1'b1);
        send(OP_ADD, 5'd6, 5'd0, 5'd0, 16'd0, 1'b0);
        wait_drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            wb_ready = ($urandom_range(0, 3) != 0);
            issue_once(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 9)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 16'($urandom), 1'($urandom), 1'b0, acc);
        end
        wait_drain();

        // Reset mid-stream with both stages full
        wb_ready = 1'b0;
        send(OP_ADD, 5'd1, 5'd0, 5'd0, 16'h0011, 1'b1);
        send(OP_OR, 5'd2, 5'd0, 5'd0, 16'h0055, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_reset_full", {wb_valid, alu_control}, {1'b1, OP_OR});
        rst_n = 1'b0;
        #1;
        chk("async_reset_clears", {wb_valid, wb_data, alu_operand_a, alu_operand_b, alu_control}, 0);
        expq.delete();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        for (int r = 1; r < 32; r++) send(OP_OR, 5'd0, 5'(r), 5'(r), 16'd0, 1'b0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
